// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: decodes opcodes into registered datapath controls and sequences memory transfers.
// Latency: ALU ops 1 cycle (1/cycle throughput); loads N+3 edges, stores N+2 edges for N busy cycles.
// Backpressure: OP_ACCEPT drops during memory transfers, write-back and fault; PC_STALL holds fetch meanwhile.
module mc_control_unit #(
    parameter int OP_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [OP_WIDTH-1:0] OP,
    input  logic                OP_VALID,
    output logic                OP_ACCEPT,
    input  logic                BUSYWAIT,
    input  logic                CLEAR_FAULT,
    output logic                PC_STALL,
    output logic [2:0]          ALUOP,
    output logic [1:0]          SHIFTOP,
    output logic                MUX_2SCMPL,
    output logic                MUX_IMMD,
    output logic                WRITEENABLE,
    output logic                BEQ_ENABLE,
    output logic                BNE_ENABLE,
    output logic                JUMP_ENABLE,
    output logic                SHIFT_ENABLE,
    output logic                READ,
    output logic                WRITE,
    output logic                MUX_WRITEDATA,
    output logic                FAULT,
    output logic [1:0]          FAULT_CODE
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_WAIT,
        S_WBACK,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] shiftop;
        logic       mux_2scmpl;
        logic       mux_immd;
        logic       writeenable;
        logic       beq_enable;
        logic       bne_enable;
        logic       jump_enable;
        logic       shift_enable;
        logic       read;
        logic       write;
        logic       mux_writedata;
    } ctrl_t;

    state_t           state;
    ctrl_t            ctrl_q;
    ctrl_t            dec_ctrl;
    logic             op_legal;
    logic             dec_mem;
    logic             mem_op;
    logic [CNT_W-1:0] busy_cnt;

    // Registered controls of the op currently in flight; memory ops are identified by READ/WRITE.
    assign mem_op = ctrl_q.read | ctrl_q.write;

    // Opcode decode; the write-enable of a load is deferred to the write-back cycle.
    always_comb begin
        dec_ctrl = '0;
        op_legal = ((OP >> 5) == '0);
        case (OP[4:0])
            5'h00: begin dec_ctrl.mux_immd = 1'b1; dec_ctrl.writeenable = 1'b1; end
            5'h01: begin dec_ctrl.writeenable = 1'b1; end
            5'h02: begin dec_ctrl.aluop = 3'b001; dec_ctrl.writeenable = 1'b1; end
            5'h03: begin dec_ctrl.aluop = 3'b001; dec_ctrl.mux_2scmpl = 1'b1; dec_ctrl.writeenable = 1'b1; end
            5'h04: begin dec_ctrl.aluop = 3'b010; dec_ctrl.writeenable = 1'b1; end
            5'h05: begin dec_ctrl.aluop = 3'b011; dec_ctrl.writeenable = 1'b1; end
            5'h06: begin dec_ctrl.aluop = 3'b111; dec_ctrl.jump_enable = 1'b1; end
            5'h07: begin dec_ctrl.aluop = 3'b001; dec_ctrl.mux_2scmpl = 1'b1; dec_ctrl.beq_enable = 1'b1; end
            5'h08: begin dec_ctrl.read = 1'b1; dec_ctrl.mux_writedata = 1'b1; end
            5'h09: begin dec_ctrl.read = 1'b1; dec_ctrl.mux_writedata = 1'b1; dec_ctrl.mux_immd = 1'b1; end
            5'h0A: begin dec_ctrl.write = 1'b1; end
            5'h0B: begin dec_ctrl.write = 1'b1; dec_ctrl.mux_immd = 1'b1; end
            5'h0C: begin dec_ctrl.aluop = 3'b100; dec_ctrl.writeenable = 1'b1; end
            5'h0D: begin
                dec_ctrl.aluop = 3'b101; dec_ctrl.shiftop = 2'b11; dec_ctrl.shift_enable = 1'b1;
                dec_ctrl.mux_immd = 1'b1; dec_ctrl.writeenable = 1'b1;
            end
            5'h0E: begin
                dec_ctrl.aluop = 3'b101; dec_ctrl.shiftop = 2'b00; dec_ctrl.shift_enable = 1'b1;
                dec_ctrl.mux_immd = 1'b1; dec_ctrl.writeenable = 1'b1;
            end
            5'h0F: begin
                dec_ctrl.aluop = 3'b110; dec_ctrl.shiftop = 2'b01; dec_ctrl.shift_enable = 1'b1;
                dec_ctrl.mux_immd = 1'b1; dec_ctrl.writeenable = 1'b1;
            end
            5'h10: begin
                dec_ctrl.aluop = 3'b110; dec_ctrl.shiftop = 2'b10; dec_ctrl.shift_enable = 1'b1;
                dec_ctrl.mux_immd = 1'b1; dec_ctrl.writeenable = 1'b1;
            end
            5'h11: begin dec_ctrl.aluop = 3'b111; dec_ctrl.mux_2scmpl = 1'b1; dec_ctrl.bne_enable = 1'b1; end
            default: op_legal = 1'b0;
        endcase
        if (!op_legal) begin
            dec_ctrl = '0;
        end
        dec_mem = dec_ctrl.read | dec_ctrl.write;
    end

    // Accept only from IDLE or from EXEC of a non-memory op, giving 1 op/cycle for ALU streams.
    always_comb begin
        OP_ACCEPT = OP_VALID && ((state == S_IDLE) || ((state == S_EXEC) && !mem_op));
    end

    // Control FSM; every output is registered so reset clears them immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            ctrl_q     <= '0;
            busy_cnt   <= '0;
            PC_STALL   <= 1'b0;
            FAULT      <= 1'b0;
            FAULT_CODE <= FC_NONE;
        end else begin
            case (state)
                S_IDLE, S_EXEC: begin
                    if ((state == S_EXEC) && mem_op) begin
                        state    <= S_MEM_WAIT;
                        busy_cnt <= '0;
                    end else if (OP_VALID && op_legal) begin
                        state    <= S_EXEC;
                        ctrl_q   <= dec_ctrl;
                        PC_STALL <= dec_mem;
                    end else if (OP_VALID) begin
                        state      <= S_FAULT;
                        ctrl_q     <= '0;
                        PC_STALL   <= 1'b1;
                        FAULT      <= 1'b1;
                        FAULT_CODE <= FC_ILLEGAL;
                    end else begin
                        state    <= S_IDLE;
                        ctrl_q   <= '0;
                        PC_STALL <= 1'b0;
                    end
                end
                S_MEM_WAIT: begin
                    if (BUSYWAIT) begin
                        if (busy_cnt == CNT_LAST) begin
                            state      <= S_FAULT;
                            ctrl_q     <= '0;
                            FAULT      <= 1'b1;
                            FAULT_CODE <= FC_TIMEOUT;
                        end else begin
                            busy_cnt <= busy_cnt + CNT_W'(1);
                        end
                    end else if (ctrl_q.read) begin
                        state                <= S_WBACK;
                        ctrl_q.read          <= 1'b0;
                        ctrl_q.mux_writedata <= 1'b1;
                        ctrl_q.writeenable   <= 1'b1;
                    end else begin
                        state    <= S_IDLE;
                        ctrl_q   <= '0;
                        PC_STALL <= 1'b0;
                    end
                end
                S_WBACK: begin
                    state    <= S_IDLE;
                    ctrl_q   <= '0;
                    PC_STALL <= 1'b0;
                end
                S_FAULT: begin
                    if (CLEAR_FAULT) begin
                        state      <= S_IDLE;
                        PC_STALL   <= 1'b0;
                        FAULT      <= 1'b0;
                        FAULT_CODE <= FC_NONE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ctrl_q   <= '0;
                    PC_STALL <= 1'b0;
                end
            endcase
        end
    end

    assign ALUOP         = ctrl_q.aluop;
    assign SHIFTOP       = ctrl_q.shiftop;
    assign MUX_2SCMPL    = ctrl_q.mux_2scmpl;
    assign MUX_IMMD      = ctrl_q.mux_immd;
    assign WRITEENABLE   = ctrl_q.writeenable;
    assign BEQ_ENABLE    = ctrl_q.beq_enable;
    assign BNE_ENABLE    = ctrl_q.bne_enable;
    assign JUMP_ENABLE   = ctrl_q.jump_enable;
    assign SHIFT_ENABLE  = ctrl_q.shift_enable;
    assign READ          = ctrl_q.read;
    assign WRITE         = ctrl_q.write;
    assign MUX_WRITEDATA = ctrl_q.mux_writedata;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scenario bench for mc_control_unit: per-cycle stimulus tables with expected outputs via a scoreboard queue.
// Latency: expected vector for each cycle is compared 1 ns after inputs are applied, mid-cycle.
// Backpressure: OP_ACCEPT is part of every compared vector.
module tb_mc_control_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] OP = '0;
    logic       OP_VALID = 1'b0;
    logic       OP_ACCEPT;
    logic       BUSYWAIT = 1'b0;
    logic       CLEAR_FAULT = 1'b0;
    logic       PC_STALL;
    logic [2:0] ALUOP;
    logic [1:0] SHIFTOP;
    logic       MUX_2SCMPL, MUX_IMMD, WRITEENABLE, BEQ_ENABLE, BNE_ENABLE, JUMP_ENABLE;
    logic       SHIFT_ENABLE, READ, WRITE, MUX_WRITEDATA, FAULT;
    logic [1:0] FAULT_CODE;

    int n_vec = 0;
    int n_err = 0;

    // Flag order: {m2scmpl, immd, we, beq, bne, jump, shift_en, read, write, mux_writedata}
    typedef struct packed {
        logic       acc;
        logic       stall;
        logic [2:0] aluop;
        logic [1:0] shiftop;
        logic [9:0] flags;
        logic       flt;
        logic [1:0] fcode;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [7:0] op;
        logic       busy;
        logic       clr;
    } stim_t;

    obs_t obs;
    obs_t sb_q[$];

    assign obs = {OP_ACCEPT, PC_STALL, ALUOP, SHIFTOP,
                  MUX_2SCMPL, MUX_IMMD, WRITEENABLE, BEQ_ENABLE, BNE_ENABLE, JUMP_ENABLE,
                  SHIFT_ENABLE, READ, WRITE, MUX_WRITEDATA, FAULT, FAULT_CODE};

    mc_control_unit #(.OP_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .OP(OP), .OP_VALID(OP_VALID), .OP_ACCEPT(OP_ACCEPT),
        .BUSYWAIT(BUSYWAIT), .CLEAR_FAULT(CLEAR_FAULT), .PC_STALL(PC_STALL),
        .ALUOP(ALUOP), .SHIFTOP(SHIFTOP), .MUX_2SCMPL(MUX_2SCMPL), .MUX_IMMD(MUX_IMMD),
        .WRITEENABLE(WRITEENABLE), .BEQ_ENABLE(BEQ_ENABLE), .BNE_ENABLE(BNE_ENABLE),
        .JUMP_ENABLE(JUMP_ENABLE), .SHIFT_ENABLE(SHIFT_ENABLE), .READ(READ), .WRITE(WRITE),
        .MUX_WRITEDATA(MUX_WRITEDATA), .FAULT(FAULT), .FAULT_CODE(FAULT_CODE)
    );

    always #5 CLK = ~CLK;

    function automatic stim_t s(input logic r, input logic v, input logic [7:0] o,
                                input logic b, input logic c);
        s = {r, v, o, b, c};
    endfunction

    function automatic obs_t mk(input logic acc, input logic stall, input logic [2:0] alu,
                                input logic [1:0] sh, input logic [9:0] f,
                                input logic flt, input logic [1:0] fc);
        mk = {acc, stall, alu, sh, f, flt, fc};
    endfunction

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  want;
        st.push_back(s(0, 0, 8'h00, 0, 0)); ex.push_back('0);
        st.push_back(s(1, 1, 8'h08, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0000000101, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0000000101, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0000000101, 0, 2'b00));
        st.push_back(s(0, 0, 8'h00, 1, 0)); ex.push_back('0);
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        st.push_back(s(1, 1, 8'h01, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 0, 3'b000, 2'b00, 10'b0010000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        for (int i = 0; i < st.size(); i++) begin
            RESET = st[i].rst; OP_VALID = st[i].vld; OP = st[i].op;
            BUSYWAIT = st[i].busy; CLEAR_FAULT = st[i].clr;
            sb_q.push_back(ex[i]);
            #1;
            want = sb_q.pop_front();
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %b want %b", i, obs, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  want;
        st.push_back(s(1, 1, 8'h02, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 1, 8'h03, 0, 1)); ex.push_back(mk(1, 0, 3'b001, 2'b00, 10'b0010000000, 0, 2'b00));
        st.push_back(s(1, 1, 8'h0F, 0, 0)); ex.push_back(mk(1, 0, 3'b001, 2'b00, 10'b1010000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 0, 3'b110, 2'b01, 10'b0110001000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        for (int i = 0; i < st.size(); i++) begin
            RESET = st[i].rst; OP_VALID = st[i].vld; OP = st[i].op;
            BUSYWAIT = st[i].busy; CLEAR_FAULT = st[i].clr;
            sb_q.push_back(ex[i]);
            #1;
            want = sb_q.pop_front();
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_wait();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  want;
        // lwi with 3 busy edges; OP_VALID held with add during the transfer must not be taken
        st.push_back(s(1, 1, 8'h09, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0100000101, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0100000101, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0100000101, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 1, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0100000101, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 0, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0100000101, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 0, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0110000001, 0, 2'b00));
        st.push_back(s(1, 1, 8'h02, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 0, 3'b001, 2'b00, 10'b0010000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        for (int i = 0; i < st.size(); i++) begin
            RESET = st[i].rst; OP_VALID = st[i].vld; OP = st[i].op;
            BUSYWAIT = st[i].busy; CLEAR_FAULT = st[i].clr;
            sb_q.push_back(ex[i]);
            #1;
            want = sb_q.pop_front();
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL load_wait cyc%0d: got %b want %b", i, obs, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_store_nowait();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  want;
        st.push_back(s(1, 1, 8'h0A, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0000000010, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 1, 3'b000, 2'b00, 10'b0000000010, 0, 2'b00));
        st.push_back(s(1, 1, 8'h04, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 0, 3'b010, 2'b00, 10'b0010000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        for (int i = 0; i < st.size(); i++) begin
            RESET = st[i].rst; OP_VALID = st[i].vld; OP = st[i].op;
            BUSYWAIT = st[i].busy; CLEAR_FAULT = st[i].clr;
            sb_q.push_back(ex[i]);
            #1;
            want = sb_q.pop_front();
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL store_nowait cyc%0d: got %b want %b", i, obs, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  want;
        obs_t  f01;
        f01 = mk(0, 1, 3'b000, 2'b00, 10'b0000000000, 1, 2'b01);
        st.push_back(s(1, 1, 8'h12, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(f01);
        st.push_back(s(1, 1, 8'h00, 0, 0)); ex.push_back(f01);
        st.push_back(s(1, 1, 8'h00, 0, 1)); ex.push_back(f01);
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        st.push_back(s(1, 1, 8'h80, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(f01);
        st.push_back(s(1, 0, 8'h00, 0, 1)); ex.push_back(f01);
        st.push_back(s(1, 1, 8'h00, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back(mk(0, 0, 3'b000, 2'b00, 10'b0110000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        for (int i = 0; i < st.size(); i++) begin
            RESET = st[i].rst; OP_VALID = st[i].vld; OP = st[i].op;
            BUSYWAIT = st[i].busy; CLEAR_FAULT = st[i].clr;
            sb_q.push_back(ex[i]);
            #1;
            want = sb_q.pop_front();
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL illegal cyc%0d: got %b want %b", i, obs, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  want;
        obs_t  lwd;
        obs_t  f10;
        lwd = mk(0, 1, 3'b000, 2'b00, 10'b0000000101, 0, 2'b00);
        f10 = mk(0, 1, 3'b000, 2'b00, 10'b0000000000, 1, 2'b10);
        st.push_back(s(1, 1, 8'h08, 0, 0)); ex.push_back(mk(1, 0, 3'b000, 2'b00, 10'b0000000000, 0, 2'b00));
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(lwd);
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(lwd);
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(lwd);
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(lwd);
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(lwd);
        st.push_back(s(1, 0, 8'h00, 1, 0)); ex.push_back(f10);
        st.push_back(s(1, 1, 8'h02, 1, 0)); ex.push_back(f10);
        st.push_back(s(1, 0, 8'h00, 0, 1)); ex.push_back(f10);
        st.push_back(s(1, 0, 8'h00, 0, 0)); ex.push_back('0);
        for (int i = 0; i < st.size(); i++) begin
            RESET = st[i].rst; OP_VALID = st[i].vld; OP = st[i].op;
            BUSYWAIT = st[i].busy; CLEAR_FAULT = st[i].clr;
            sb_q.push_back(ex[i]);
            #1;
            want = sb_q.pop_front();
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL timeout cyc%0d: got %b want %b", i, obs, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_store_nowait();
        test_illegal();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle, parametrised successor to the single-cycle CPU control unit. Sits between instruction fetch and the datapath: accepts opcodes over a valid/accept handshake, registers decoded control signals, sequences data-memory transfers against `BUSYWAIT`, and stalls the PC while memory is busy. Adds a watchdog timeout and illegal-opcode detection, both reported through a sticky fault state.

## Interface
- `OP_WIDTH`, 8: opcode width. Must be ≥ 5; bits above [4:0] must be zero for a legal opcode.
- `TIMEOUT_CYCLES`, 64: maximum consecutive `BUSYWAIT`-high cycles in MEM_WAIT before a fault. Range 1..65535. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `OP` in `OP_WIDTH`: opcode from fetch.
- `OP_VALID` in 1: `OP` is valid this cycle.
- `OP_ACCEPT` out 1: combinational; the opcode is taken at this rising edge.
- `BUSYWAIT` in 1: data memory busy.
- `CLEAR_FAULT` in 1: leave FAULT.
- `PC_STALL` out 1: fetch must hold the PC.
- `ALUOP` out 3: ALU operation.
- `SHIFTOP` out 2: shift type.
- `MUX_2SCMPL`, `MUX_IMMD`, `WRITEENABLE`, `BEQ_ENABLE`, `BNE_ENABLE`, `JUMP_ENABLE`, `SHIFT_ENABLE`, `READ`, `WRITE`, `MUX_WRITEDATA` out 1 each: datapath and memory controls.
- `FAULT` out 1: fault state active.
- `FAULT_CODE` out 2: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- Decode (opcode → ALUOP):
  - 0x00 loadi, 0x01 mov: 000.
  - 0x02 add, 0x03 sub: 001.
  - 0x04 and: 010.
  - 0x05 or: 011.
  - 0x06 j: 111.
  - 0x07 beq: 001.
  - 0x08 lwd, 0x09 lwi, 0x0A swd, 0x0B swi: 000.
  - 0x0C mult: 100.
  - 0x0D sll, 0x0E srl: 101.
  - 0x0F sra, 0x10 ror: 110.
  - 0x11 bne: 111.
  - Any other value is illegal.
- SHIFTOP: sll 11, srl 00, sra 01, ror 10; all other opcodes 00. No X is ever driven.
- SHIFT_ENABLE: sll, srl, sra, ror.
- MUX_IMMD: loadi, sll, srl, sra, ror, lwi, swi.
- MUX_2SCMPL: sub, beq, bne.
- BEQ_ENABLE: beq. BNE_ENABLE: bne. JUMP_ENABLE: j.
- MUX_WRITEDATA: lwd, lwi.
- READ: lwd, lwi. WRITE: swd, swi.
- WRITEENABLE: loadi, mov, add, sub, and, or, mult, shifts and loads. Never asserted for j, beq, bne or stores.
- FSM states: IDLE, EXEC, MEM_WAIT, WBACK, FAULT.
- IDLE:
  - `OP_ACCEPT = OP_VALID`.
  - On accept of a legal opcode: register the decoded controls and go to EXEC.
  - On accept of an illegal opcode: go to FAULT with code 01.
- EXEC: registered controls drive the outputs.
  - Non-memory op: `OP_ACCEPT = OP_VALID`, so back-to-back accept is allowed. Legal → EXEC, illegal → FAULT, no valid → IDLE.
  - Memory op: `OP_ACCEPT = 0`, READ/WRITE asserted, WRITEENABLE forced 0, go to MEM_WAIT.
- MEM_WAIT:
  - READ/WRITE, ALUOP and MUX_* held; WRITEENABLE = 0; `OP_ACCEPT = 0`.
  - Each edge with BUSYWAIT=1: timeout counter +1. When the counter reaches `TIMEOUT_CYCLES`, go to FAULT with code 10.
  - First edge with BUSYWAIT=0: loads → WBACK; stores → IDLE.
- WBACK: one cycle. READ = 0, MUX_WRITEDATA = 1, WRITEENABLE = 1, `OP_ACCEPT = 0`, then → IDLE.
- FAULT:
  - All control outputs 0; FAULT = 1; FAULT_CODE held; `OP_ACCEPT = 0`.
  - CLEAR_FAULT=1 at an edge → IDLE with FAULT_CODE = 00.
- Timeout counter clears on every entry to MEM_WAIT.
- `PC_STALL` = 1 in MEM_WAIT, WBACK and FAULT. It is also 1 in EXEC of a memory op.

## Timing
- Reset (RESET=0, asynchronous):
  - State → IDLE; counter = 0.
  - All control outputs, `PC_STALL`, `FAULT` = 0; `FAULT_CODE` = 00.
  - Applies immediately, including mid-transfer. A reset during MEM_WAIT drops READ/WRITE without waiting for the edge.
- Non-memory op: accepted at edge k; controls valid from k until edge k+1. Sustained throughput is 1 op per cycle.
- Load with N busy cycles:
  - Accepted at edge k; EXEC during [k, k+1).
  - MEM_WAIT from k+1 to edge k+1+N+1.
  - WBACK for 1 cycle.
  - Total from accept to IDLE: N+3 edges.
- Store with N busy cycles: N+2 edges.
- The memory raises BUSYWAIT combinationally with READ/WRITE. BUSYWAIT=0 on the first MEM_WAIT edge means zero wait states.
- Timeout: FAULT is asserted after `TIMEOUT_CYCLES` consecutive busy edges in MEM_WAIT.
- CLEAR_FAULT outside FAULT is ignored.
- CLEAR_FAULT together with OP_VALID in FAULT: the fault is cleared and the opcode is not accepted.
- OP is sampled only at accepting edges. OP changes while `OP_ACCEPT = 0` have no effect.

## Test plan
- Reset: RESET=0 asynchronously mid-MEM_WAIT of an lwd → READ=0 and PC_STALL=0 within 0 cycles; after release the state is IDLE, FAULT_CODE = 00.
- Back-to-back ALU ops: OP_VALID held with 0x02, 0x03, 0x0F → OP_ACCEPT=1 on 3 consecutive edges; outputs in sequence:
  - ALUOP 001, MUX_2SCMPL 0.
  - ALUOP 001, MUX_2SCMPL 1.
  - ALUOP 110, SHIFT_ENABLE 1, SHIFTOP 01, MUX_IMMD 1.
- lwi with BUSYWAIT high for 3 cycles → READ high for 5 cycles (EXEC plus 4 MEM_WAIT), then 1 WBACK cycle with WRITEENABLE=1 and MUX_WRITEDATA=1; OP_ACCEPT returns 6 edges after the accept.
- swd with zero wait states → WRITE high for 2 cycles, WRITEENABLE never 1, back in IDLE after 2 edges.
- Illegal opcode 0x12, then 0x80 → FAULT=1, FAULT_CODE=01, all controls 0; CLEAR_FAULT=1 → IDLE; the next 0x00 is accepted with MUX_IMMD=1 and WRITEENABLE=1.
- TIMEOUT_CYCLES=4, lwd with BUSYWAIT stuck high → FAULT_CODE=10 after 4 busy edges, READ=0, PC_STALL=1 until CLEAR_FAULT.
